// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32I multi-cycle control sequencer.
//   - RV32I major opcodes
//   - immediate format select encoding (IMM_I .. IMM_UJ)
//   - ALU operation encoding ({funct7[5], funct3} style)
//   - write-back mux select encoding
//   - sequencer state enum and decoded instruction class enum
package riscv_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    IMM_I  = 3'd0,
    IMM_S  = 3'd1,
    IMM_U  = 3'd2,
    IMM_SB = 3'd3,
    IMM_UJ = 3'd4
  } imm_sel_e;

  // ALU codes are {funct7[5], funct3}, so R-type and shift-immediate
  // instructions pass their fields straight through.
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_TRAP
  } state_e;

  typedef enum logic [3:0] {
    CLS_ILLEGAL,
    CLS_OP,
    CLS_OP_IMM,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_LUI,
    CLS_AUIPC,
    CLS_JAL,
    CLS_JALR
  } instr_class_e;

endpackage

// File: rtl/riscv_opcode_decode.sv
// Combinational opcode decoder.
//   opcode   in  : instruction[6:0]
//   cls      out : instruction class (CLS_ILLEGAL for unknown opcodes)
//   imm_sel  out : immediate format for the immediate generator
// R-type has no immediate; it reports IMM_I so the select stays at I.
module riscv_opcode_decode
  import riscv_pkg::*;
(
  input  logic [6:0]   opcode,
  output instr_class_e cls,
  output imm_sel_e     imm_sel
);

  // NOTE: every output gets a default before the case so no path through
  // this block leaves a signal unassigned, which would infer a latch.
  always_comb begin
    cls     = CLS_ILLEGAL;
    imm_sel = IMM_I;
    case (opcode)
      OPC_OP:     cls = CLS_OP;
      OPC_OP_IMM: cls = CLS_OP_IMM;
      OPC_LOAD:   cls = CLS_LOAD;
      OPC_JALR:   cls = CLS_JALR;
      OPC_STORE: begin
        cls     = CLS_STORE;
        imm_sel = IMM_S;
      end
      OPC_LUI: begin
        cls     = CLS_LUI;
        imm_sel = IMM_U;
      end
      OPC_AUIPC: begin
        cls     = CLS_AUIPC;
        imm_sel = IMM_U;
      end
      OPC_BRANCH: begin
        cls     = CLS_BRANCH;
        imm_sel = IMM_SB;
      end
      OPC_JAL: begin
        cls     = CLS_JAL;
        imm_sel = IMM_UJ;
      end
      default: begin
        cls     = CLS_ILLEGAL;
        imm_sel = IMM_I;
      end
    endcase
  end

endmodule

// File: rtl/riscv_mc_ctrl.sv
// Multi-cycle control sequencer for an RV32I datapath.
// Steps FETCH -> DECODE -> EXEC -> [MEM] -> [WB] -> FETCH, with TRAP as a
// sink for illegal opcodes (left only by reset).
//   clk, reset_n                 : clock, asynchronous active-low reset
//   opcode, funct3, funct7_b5    : fields of the latched instruction
//   branch_taken                 : compare result, sampled in EXEC
//   imem_ready / imem_req        : instruction fetch handshake
//   dmem_ready / dmem_req/dmem_we: data access handshake
//   ir_we, pc_we, pc_sel, reg_we, wb_sel             : datapath enables/muxes
//   alu_src_a, alu_src_b, alu_op, imm_sel            : ALU / immediate control
//   illegal_instr                : high while parked in TRAP
// Optional build macro RISCV_MC_CTRL_PERF_EN adds cycle_cnt and instret_cnt.
module riscv_mc_ctrl
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        funct7_b5,
  input  logic        branch_taken,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_sel,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        alu_src_a,
  output logic        alu_src_b,
  output logic [3:0]  alu_op,
  output logic [2:0]  imm_sel,
  output logic        illegal_instr
`ifdef RISCV_MC_CTRL_PERF_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
`endif
);

  state_e       state_q, state_d;
  instr_class_e cls_q, cls_d;
  imm_sel_e     imm_sel_q, imm_sel_d;
  instr_class_e dec_cls;
  imm_sel_e     dec_imm;

  riscv_opcode_decode u_decode (
    .opcode  (opcode),
    .cls     (dec_cls),
    .imm_sel (dec_imm)
  );

  // Next state; class and immediate format are captured only in DECODE.
  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    imm_sel_d = imm_sel_q;
    case (state_q)
      ST_FETCH:  if (imem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        if (dec_cls == CLS_ILLEGAL) begin
          state_d = ST_TRAP;
        end else begin
          state_d   = ST_EXEC;
          cls_d     = dec_cls;
          imm_sel_d = dec_imm;
        end
      end
      ST_EXEC: begin
        case (cls_q)
          CLS_BRANCH:          state_d = ST_FETCH;
          CLS_LOAD, CLS_STORE: state_d = ST_MEM;
          default:             state_d = ST_WB;
        endcase
      end
      ST_MEM: if (dmem_ready) state_d = (cls_q == CLS_STORE) ? ST_FETCH : ST_WB;
      ST_WB:   state_d = ST_FETCH;
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_FETCH;
      cls_q     <= CLS_OP_IMM;
      imm_sel_q <= IMM_I;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      imm_sel_q <= imm_sel_d;
    end
  end

  // ALU operand/op selection by class. Branches use the ALU for the target
  // (PC + imm); the compare itself arrives on branch_taken. LUI adds the
  // immediate to rs1, which the datapath forces to x0.
  logic       alu_a_c, alu_b_c;
  logic [3:0] alu_op_c;
  always_comb begin
    alu_a_c  = 1'b0;
    alu_b_c  = 1'b1;
    alu_op_c = ALU_ADD;
    case (cls_q)
      CLS_OP: begin
        alu_b_c  = 1'b0;
        alu_op_c = {funct7_b5, funct3};
      end
      CLS_OP_IMM: alu_op_c = (funct3 == 3'b101) ? {funct7_b5, funct3} : {1'b0, funct3};
      CLS_AUIPC, CLS_JAL, CLS_BRANCH: alu_a_c = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    imem_req      = 1'b0;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    ir_we         = 1'b0;
    pc_we         = 1'b0;
    pc_sel        = 1'b0;
    reg_we        = 1'b0;
    wb_sel        = WB_ALU;
    alu_src_a     = 1'b0;
    alu_src_b     = 1'b0;
    alu_op        = ALU_ADD;
    illegal_instr = 1'b0;
    case (state_q)
      ST_FETCH: begin
        imem_req = 1'b1;
        ir_we    = imem_ready;
      end
      ST_EXEC: begin
        alu_src_a = alu_a_c;
        alu_src_b = alu_b_c;
        alu_op    = alu_op_c;
        if (cls_q == CLS_BRANCH) begin
          pc_we  = 1'b1;
          pc_sel = branch_taken;
        end
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls_q == CLS_STORE);
        pc_we    = dmem_ready && (cls_q == CLS_STORE);
      end
      ST_WB: begin
        // ALU controls stay driven so the ALU result used for the JAL/JALR
        // target and the write-back value is valid in this cycle too.
        alu_src_a = alu_a_c;
        alu_src_b = alu_b_c;
        alu_op    = alu_op_c;
        reg_we    = 1'b1;
        pc_we     = 1'b1;
        if (cls_q == CLS_JAL || cls_q == CLS_JALR) begin
          wb_sel = WB_PC4;
          pc_sel = 1'b1;
        end else if (cls_q == CLS_LOAD) begin
          wb_sel = WB_MEM;
        end
      end
      ST_TRAP: illegal_instr = 1'b1;
      default: ;
    endcase
    // While reset is held the state sits in FETCH; masking here keeps the
    // fetch request and every enable low until reset_n is released.
    if (!reset_n) begin
      imem_req = 1'b0;
      ir_we    = 1'b0;
    end
  end

  assign imm_sel = imm_sel_q;

`ifdef RISCV_MC_CTRL_PERF_EN
  logic [31:0] cycle_q, cycle_d, instret_q, instret_d;

  always_comb begin
    cycle_d   = cycle_q + 32'd1;
    instret_d = pc_we ? instret_q + 32'd1 : instret_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycle_q   <= 32'd0;
      instret_q <= 32'd0;
    end else begin
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
`endif

endmodule
